// File: rtl/decoder_4b5b_framer.sv
// 4B/5B receive decoder with J-K/T-R frame delineation. Decoded nibbles are packed
// into NIBBLES-wide words; each word is held back one slot so end-of-frame is exact.
module decoder_4b5b_framer #(
  parameter int NIBBLES = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [4:0]           in_code,
  output logic                 out_valid,
  output logic [4*NIBBLES-1:0] out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 out_err,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int WORD_W = 4 * NIBBLES;
  localparam int NIB_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [4:0] C_J = 5'h18;
  localparam logic [4:0] C_K = 5'h11;
  localparam logic [4:0] C_T = 5'h0D;
  localparam logic [4:0] C_R = 5'h07;

  typedef enum logic [1:0] {IDLE, GOT_J, DATA, GOT_T} state_t;

  // Returns {is_data, nibble}; control and undefined codes give is_data = 0.
  function automatic logic [4:0] decode(input logic [4:0] c);
    case (c)
      5'h1E: decode = 5'h10;  5'h09: decode = 5'h11;
      5'h14: decode = 5'h12;  5'h15: decode = 5'h13;
      5'h0A: decode = 5'h14;  5'h0B: decode = 5'h15;
      5'h0E: decode = 5'h16;  5'h0F: decode = 5'h17;
      5'h12: decode = 5'h18;  5'h13: decode = 5'h19;
      5'h16: decode = 5'h1A;  5'h17: decode = 5'h1B;
      5'h1A: decode = 5'h1C;  5'h1B: decode = 5'h1D;
      5'h1C: decode = 5'h1E;  5'h1D: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  state_t              state;
  logic [WORD_W-1:0]   fill;
  logic [WORD_W-1:0]   hold;
  logic [WORD_W-1:0]   word_next;
  logic [NIB_W-1:0]    nib;
  logic                hold_v;
  logic                hold_sop;
  logic                first;
  logic [4:0]          dec;
  logic                dec_v;
  logic [3:0]          dec_nib;
  logic                nib_last;
  logic                accept;

  assign dec      = decode(in_code);
  assign dec_v    = dec[4];
  assign dec_nib  = dec[3:0];
  assign nib_last = (nib == NIB_W'(NIBBLES - 1));
  assign accept   = en && in_valid;

  // Partial word with the incoming nibble dropped into its slot; first nibble lands in [3:0].
  always_comb begin
    word_next = fill;
    for (int i = 0; i < NIBBLES; i++) begin
      if (nib == NIB_W'(i)) word_next[4*i +: 4] = dec_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill      <= '0;
      hold      <= '0;
      nib       <= '0;
      hold_v    <= 1'b0;
      hold_sop  <= 1'b0;
      first     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_code == C_J) state <= GOT_J;
          end
          GOT_J: begin
            if (in_code == C_K) begin
              state  <= DATA;
              nib    <= '0;
              hold_v <= 1'b0;
              first  <= 1'b1;
            end else if (in_code != C_J) begin
              state <= IDLE;
            end
          end
          DATA: begin
            if (dec_v) begin
              if (nib_last) begin
                if (hold_v) begin
                  out_valid <= 1'b1;
                  out_data  <= hold;
                  out_sop   <= hold_sop;
                  out_eop   <= 1'b0;
                end
                hold     <= word_next;
                hold_v   <= 1'b1;
                hold_sop <= first;
                first    <= 1'b0;
                nib      <= '0;
              end else begin
                fill <= word_next;
                nib  <= nib + 1'b1;
              end
            end else if (in_code == C_T) begin
              state <= GOT_T;
            end else begin
              state   <= IDLE;
              nib     <= '0;
              hold_v  <= 1'b0;
              out_err <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
            end
          end
          GOT_T: begin
            state <= IDLE;
            if (in_code == C_R && nib == '0) begin
              // An empty frame closes silently; otherwise the held word is the last one.
              if (hold_v) begin
                out_valid <= 1'b1;
                out_data  <= hold;
                out_sop   <= hold_sop;
                out_eop   <= 1'b1;
              end
              hold_v <= 1'b0;
            end else begin
              nib     <= '0;
              hold_v  <= 1'b0;
              out_err <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_4b5b_framer.sv
// Directed bench for decoder_4b5b_framer: two instances (NIBBLES=2/CNT_W=8 and
// NIBBLES=4/CNT_W=2) driven from one stimulus stream, scored against expected queues.
module tb_decoder_4b5b_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b1;
  logic        en_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_code = 5'h00;

  logic        a_valid, a_sop, a_eop, a_err;
  logic [7:0]  a_data;
  logic [7:0]  a_cnt;
  logic        b_valid, b_sop, b_eop, b_err;
  logic [15:0] b_data;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  decoder_4b5b_framer #(.NIBBLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .in_valid(in_valid), .in_code(in_code),
    .out_valid(a_valid), .out_data(a_data), .out_sop(a_sop), .out_eop(a_eop),
    .out_err(a_err), .err_cnt(a_cnt)
  );

  decoder_4b5b_framer #(.NIBBLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .in_valid(in_valid), .in_code(in_code),
    .out_valid(b_valid), .out_data(b_data), .out_sop(b_sop), .out_eop(b_eop),
    .out_err(b_err), .err_cnt(b_cnt)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } wexp_t;

  wexp_t qa[$];
  wexp_t qb[$];
  int    ea[$];
  int    eb[$];
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  string tname = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s/%s: observed %0h expected %0h", tname, tag, obs, exp);
    end
  endtask

  task automatic check_outputs;
    logic exp_e;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      chk("a_valid", 32'(a_valid), 32'd1);
      chk("a_data",  32'(a_data),  qa[0].data);
      chk("a_sop",   32'(a_sop),   32'(qa[0].sop));
      chk("a_eop",   32'(a_eop),   32'(qa[0].eop));
      void'(qa.pop_front());
    end else begin
      chk("a_valid", 32'(a_valid), 32'd0);
    end
    exp_e = (ea.size() > 0 && ea[0] == cyc);
    if (exp_e) void'(ea.pop_front());
    chk("a_err", 32'(a_err), 32'(exp_e));
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      chk("b_valid", 32'(b_valid), 32'd1);
      chk("b_data",  32'(b_data),  qb[0].data);
      chk("b_sop",   32'(b_sop),   32'(qb[0].sop));
      chk("b_eop",   32'(b_eop),   32'(qb[0].eop));
      void'(qb.pop_front());
    end else begin
      chk("b_valid", 32'(b_valid), 32'd0);
    end
    exp_e = (eb.size() > 0 && eb[0] == cyc);
    if (exp_e) void'(eb.pop_front());
    chk("b_err", 32'(b_err), 32'(exp_e));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  // Expectations are queued against the cycle right after the next accepting edge.
  task automatic exp_word_a(input logic [31:0] d, input logic s, input logic e);
    qa.push_back('{cyc + 1, d, s, e});
  endtask

  task automatic exp_word_b(input logic [31:0] d, input logic s, input logic e);
    qb.push_back('{cyc + 1, d, s, e});
  endtask

  task automatic exp_err_a;
    ea.push_back(cyc + 1);
  endtask

  task automatic exp_err_b;
    eb.push_back(cyc + 1);
  endtask

  task automatic sym(input logic [4:0] c);
    in_valid = 1'b1;
    in_code  = c;
    tick();
    in_valid = 1'b0;
  endtask

  // Gap cycles present a J with in_valid low; it must be ignored.
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_code  = 5'h18;
    repeat (n) tick();
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_a_data", 32'(a_data), 32'd0);
    chk("rst_a_sop",  32'(a_sop),  32'd0);
    chk("rst_a_eop",  32'(a_eop),  32'd0);
    chk("rst_a_cnt",  32'(a_cnt),  32'd0);
    chk("rst_b_data", 32'(b_data), 32'd0);
    chk("rst_b_cnt",  32'(b_cnt),  32'd0);
  endtask

  initial begin
    tname = "t1_two_words";
    do_reset();
    sym(5'h18); sym(5'h11); sym(5'h1E); sym(5'h09); sym(5'h14);
    exp_word_a(32'h10, 1'b1, 1'b0);
    sym(5'h15);
    sym(5'h0D);
    exp_word_a(32'h32, 1'b0, 1'b1);
    sym(5'h07);
    idle(2);
    chk("hold_data", 32'(a_data), 32'h32);
    chk("hold_eop",  32'(a_eop),  32'd1);
    chk("cnt", 32'(a_cnt), 32'd0);

    tname = "t2_single_word";
    do_reset();
    sym(5'h18); sym(5'h18); sym(5'h11); sym(5'h1D); sym(5'h1C); sym(5'h0D);
    exp_word_a(32'hEF, 1'b1, 1'b1);
    sym(5'h07);
    idle(3);
    chk("hold_data", 32'(a_data), 32'hEF);
    chk("hold_sop",  32'(a_sop),  32'd1);

    tname = "t3_abort_held";
    do_reset();
    sym(5'h18); sym(5'h1E); sym(5'h11); sym(5'h1E); sym(5'h09); sym(5'h0D); sym(5'h07);
    sym(5'h18); sym(5'h11); sym(5'h1E); sym(5'h09);
    exp_err_a();
    sym(5'h1F);
    idle(1);
    chk("cnt", 32'(a_cnt), 32'd1);

    tname = "t4_odd_and_empty";
    do_reset();
    sym(5'h18); sym(5'h11); sym(5'h1E); sym(5'h0D);
    exp_err_a();
    sym(5'h07);
    chk("cnt_odd", 32'(a_cnt), 32'd1);
    sym(5'h18); sym(5'h11); sym(5'h0D); sym(5'h07);
    idle(1);
    chk("cnt_empty", 32'(a_cnt), 32'd1);

    tname = "t5_gaps_en_rst";
    do_reset();
    sym(5'h18); idle(2); sym(5'h11); sym(5'h1E); idle(1); sym(5'h09);
    en_a     = 1'b0;
    in_valid = 1'b1;
    in_code  = 5'h1F;
    repeat (3) tick();
    en_a = 1'b1;
    sym(5'h14);
    do_reset();
    sym(5'h11); sym(5'h1E); sym(5'h09); sym(5'h15); sym(5'h0A); sym(5'h0D); sym(5'h07);
    chk("cnt_after_rst", 32'(a_cnt), 32'd0);
    sym(5'h18); sym(5'h11); sym(5'h1D); sym(5'h1C); sym(5'h0D);
    exp_word_a(32'hEF, 1'b1, 1'b1);
    sym(5'h07);
    idle(1);

    tname = "t6_wide_saturate";
    en_a = 1'b0;
    en_b = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sym(5'h18); sym(5'h11);
      exp_err_b();
      sym(5'h1F);
      if (i == 2) chk("b_cnt_3", 32'(b_cnt), 32'd3);
    end
    chk("b_cnt_sat", 32'(b_cnt), 32'd3);
    sym(5'h18); sym(5'h11); sym(5'h09); sym(5'h14); sym(5'h15); sym(5'h0A); sym(5'h0D);
    exp_word_b(32'h4321, 1'b1, 1'b1);
    sym(5'h07);
    idle(2);
    chk("a_cnt_frozen", 32'(a_cnt), 32'd0);

    tname = "end";
    chk("qa_left", 32'(qa.size()), 32'd0);
    chk("qb_left", 32'(qb.size()), 32'd0);
    chk("ea_left", 32'(ea.size()), 32'd0);
    chk("eb_left", 32'(eb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
